// File: rtl/game_pkg.sv
// Shared encodings for the game input fabric: value width, consumer select codes
// and the demux FSM states.
package game_pkg;

    localparam int VALUE_W = 5;

    typedef enum logic [1:0] {
        SEL_REGULAR = 2'b00,
        SEL_EVENODD = 2'b01,
        SEL_DRAW    = 2'b10,
        SEL_INVALID = 2'b11
    } selectT;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        DISPATCH = 2'b01,
        DONE     = 2'b10
    } stateT;

endpackage

// File: rtl/dispatch_timer.sv
// Counts consecutive DISPATCH cycles and flags the cycle on which the
// TIMEOUT_CYCLES-th one without an acknowledge completes.
module dispatch_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CountW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CountW-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CountW'(1);
        end
    end

    assign expired = enable && (count == CountW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/input_demux.sv
// Routes one shared player value to one of three game consumers with a
// valid/ack handshake. Define DEMUX_TIMEOUT_EN to abort unacknowledged dispatches.
module input_demux
    import game_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [VALUE_W-1:0] gameInput,
    input  logic [1:0]         select,
    input  logic               load,
    output logic [VALUE_W-1:0] regularRouletteIn,
    output logic [VALUE_W-1:0] evenOddRouletteIn,
    output logic [VALUE_W-1:0] drawIn,
    output logic               regularValid,
    output logic               evenOddValid,
    output logic               drawValid,
    input  logic               regularAck,
    input  logic               evenOddAck,
    input  logic               drawAck,
    output logic               busy,
    output logic               error,
    output logic [7:0]         dispatchCount
);

    stateT  state;
    selectT target;
    logic   targetAck;
    logic   accept;
    logic   timeout;

    assign accept = (state == IDLE) && load && (select != SEL_INVALID);
    assign busy   = (state != IDLE);

    // Only the latched target's acknowledge can complete a dispatch.
    always_comb begin
        targetAck = 1'b0;
        case (target)
            SEL_REGULAR: targetAck = regularAck;
            SEL_EVENODD: targetAck = evenOddAck;
            SEL_DRAW:    targetAck = drawAck;
            default:     targetAck = 1'b0;
        endcase
    end

`ifdef DEMUX_TIMEOUT_EN
    dispatch_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (accept),
        .enable (state == DISPATCH),
        .expired(timeout)
    );
`else
    // A dispatch never gives up in this build.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            target            <= SEL_REGULAR;
            regularRouletteIn <= '0;
            evenOddRouletteIn <= '0;
            drawIn            <= '0;
            regularValid      <= 1'b0;
            evenOddValid      <= 1'b0;
            drawValid         <= 1'b0;
            error             <= 1'b0;
            dispatchCount     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load && (select == SEL_INVALID)) begin
                        error <= 1'b1;
                    end else if (accept) begin
                        error  <= 1'b0;
                        target <= selectT'(select);
                        state  <= DISPATCH;
                        case (select)
                            SEL_REGULAR: begin
                                regularRouletteIn <= gameInput;
                                regularValid      <= 1'b1;
                            end
                            SEL_EVENODD: begin
                                evenOddRouletteIn <= gameInput;
                                evenOddValid      <= 1'b1;
                            end
                            default: begin
                                drawIn    <= gameInput;
                                drawValid <= 1'b1;
                            end
                        endcase
                    end
                end
                DISPATCH: begin
                    // An ack on the timeout cycle still counts as a completion.
                    if (targetAck) begin
                        regularValid  <= 1'b0;
                        evenOddValid  <= 1'b0;
                        drawValid     <= 1'b0;
                        dispatchCount <= dispatchCount + 8'd1;
                        state         <= DONE;
                    end else if (timeout) begin
                        regularValid <= 1'b0;
                        evenOddValid <= 1'b0;
                        drawValid    <= 1'b0;
                        error        <= 1'b1;
                        state        <= IDLE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_demux.sv
// Self-checking bench for input_demux: directed vectors plus a transaction-level
// model compared every cycle. DEMUX_TIMEOUT_EN enables the abort scenarios.
module tb_input_demux;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] gameInput = '0;
    logic [1:0] select = '0;
    logic       load = 1'b0;
    logic       regularAck = 1'b0;
    logic       evenOddAck = 1'b0;
    logic       drawAck = 1'b0;
    logic [4:0] regularRouletteIn, evenOddRouletteIn, drawIn;
    logic       regularValid, evenOddValid, drawValid;
    logic       busy, error;
    logic [7:0] dispatchCount;

    int checks = 0;
    int errors = 0;
    bit modelLive = 1'b0;

    localparam int TIMEOUT = 4;

    input_demux #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .gameInput(gameInput), .select(select),
        .load(load), .regularRouletteIn(regularRouletteIn),
        .evenOddRouletteIn(evenOddRouletteIn), .drawIn(drawIn),
        .regularValid(regularValid), .evenOddValid(evenOddValid),
        .drawValid(drawValid), .regularAck(regularAck), .evenOddAck(evenOddAck),
        .drawAck(drawAck), .busy(busy), .error(error), .dispatchCount(dispatchCount)
    );

    always #5 clock = ~clock;

    // Transaction model: which channel holds an outstanding value, the
    // one-cycle completion phase, and the per-channel last-delivered values.
    int  mData[3];
    int  mActive = -1;
    bit  mDoneCycle = 1'b0;
    bit  mError = 1'b0;
    int  mCount = 0;
    int  mWait = 0;
    logic [2:0] ackVec;

    always @(posedge clock) begin
        ackVec = {drawAck, evenOddAck, regularAck};
        if (reset) begin
            mData = '{0, 0, 0};
            mActive = -1;
            mDoneCycle = 1'b0;
            mError = 1'b0;
            mCount = 0;
        end else if (mDoneCycle) begin
            mDoneCycle = 1'b0;
        end else if (mActive >= 0) begin
            if (ackVec[mActive]) begin
                mActive = -1;
                mDoneCycle = 1'b1;
                mCount = (mCount + 1) % 256;
            end else begin
                mWait++;
`ifdef DEMUX_TIMEOUT_EN
                if (mWait >= TIMEOUT) begin
                    mActive = -1;
                    mError = 1'b1;
                end
`endif
            end
        end else if (load) begin
            if (select == 2'd3) begin
                mError = 1'b1;
            end else begin
                mError = 1'b0;
                mData[select] = int'(gameInput);
                mActive = int'(select);
                mWait = 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time,
                     actual, expected);
        end
    endtask

    always @(negedge clock) begin
        if (modelLive) begin
            checkOutput("model.regularData", 32'(regularRouletteIn), 32'(mData[0]));
            checkOutput("model.evenOddData", 32'(evenOddRouletteIn), 32'(mData[1]));
            checkOutput("model.drawData", 32'(drawIn), 32'(mData[2]));
            checkOutput("model.valids", 32'({drawValid, evenOddValid, regularValid}),
                        32'((mActive >= 0) ? (1 << mActive) : 0));
            checkOutput("model.busy", 32'(busy), 32'((mActive >= 0) || mDoneCycle));
            checkOutput("model.error", 32'(error), 32'(mError));
            checkOutput("model.count", 32'(dispatchCount), 32'(mCount));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [4:0] value, input logic [1:0] sel,
                                 input logic ld);
        gameInput = value;
        select = sel;
        load = ld;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        tick();
        tick();
        modelLive = 1'b1;
        reset = 1'b0;
        checkOutput("reset.count", 32'(dispatchCount), 32'd0);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.data", 32'({regularRouletteIn, evenOddRouletteIn, drawIn}), 32'd0);

        // Regular channel, ack after three valid cycles.
        applyStimulus(5'd17, 2'b00, 1'b1);
        load = 1'b0;
        checkOutput("reg.valid1", 32'(regularValid), 32'd1);
        checkOutput("reg.data", 32'(regularRouletteIn), 32'd17);
        checkOutput("reg.busy", 32'(busy), 32'd1);
        tick();
        tick();
        checkOutput("reg.valid3", 32'(regularValid), 32'd1);
        regularAck = 1'b1;
        tick();
        regularAck = 1'b0;
        checkOutput("reg.validDrop", 32'(regularValid), 32'd0);
        checkOutput("reg.doneBusy", 32'(busy), 32'd1);
        checkOutput("reg.count", 32'(dispatchCount), 32'd1);
        checkOutput("reg.others", 32'({evenOddRouletteIn, drawIn}), 32'd0);
        tick();
        checkOutput("reg.idle", 32'(busy), 32'd0);

        // Draw channel with ack already high.
        drawAck = 1'b1;
        applyStimulus(5'd9, 2'b10, 1'b1);
        load = 1'b0;
        checkOutput("draw.valid", 32'(drawValid), 32'd1);
        tick();
        checkOutput("draw.validDrop", 32'(drawValid), 32'd0);
        checkOutput("draw.done", 32'(busy), 32'd1);
        tick();
        drawAck = 1'b0;
        checkOutput("draw.idle", 32'(busy), 32'd0);
        checkOutput("draw.data", 32'(drawIn), 32'd9);

        // Invalid select, then recovery on a valid load.
        applyStimulus(5'd12, 2'b11, 1'b1);
        checkOutput("inv.error", 32'(error), 32'd1);
        checkOutput("inv.valids", 32'({drawValid, evenOddValid, regularValid}), 32'd0);
        checkOutput("inv.busy", 32'(busy), 32'd0);
        applyStimulus(5'd4, 2'b01, 1'b1);
        load = 1'b0;
        checkOutput("eo.errorClear", 32'(error), 32'd0);
        checkOutput("eo.data", 32'(evenOddRouletteIn), 32'd4);
        evenOddAck = 1'b1;
        tick();
        evenOddAck = 1'b0;
        tick();

        // Foreign ack and load during a draw dispatch are ignored.
        applyStimulus(5'd21, 2'b10, 1'b1);
        regularAck = 1'b1;
        applyStimulus(5'd30, 2'b00, 1'b1);
        regularAck = 1'b0;
        load = 1'b0;
        checkOutput("hold.drawData", 32'(drawIn), 32'd21);
        checkOutput("hold.drawValid", 32'(drawValid), 32'd1);
        checkOutput("hold.regData", 32'(regularRouletteIn), 32'd17);
        tick();
        drawAck = 1'b1;
        tick();
        drawAck = 1'b0;
        checkOutput("hold.count", 32'(dispatchCount), 32'd4);
        tick();

        // 252 more back-to-back dispatches wrap the count to zero.
        regularAck = 1'b1;
        select = 2'b00;
        load = 1'b1;
        for (int i = 0; i < 252; i++) begin
            gameInput = 5'(i % 32);
            tick();
            tick();
            tick();
        end
        load = 1'b0;
        regularAck = 1'b0;
        checkOutput("wrap.count", 32'(dispatchCount), 32'd0);
        checkOutput("wrap.data", 32'(regularRouletteIn), 32'd27);

        // Reset mid-dispatch, with load and ack also asserted.
        applyStimulus(5'd7, 2'b01, 1'b1);
        checkOutput("rst.preValid", 32'(evenOddValid), 32'd1);
        reset = 1'b1;
        evenOddAck = 1'b1;
        tick();
        reset = 1'b0;
        evenOddAck = 1'b0;
        load = 1'b0;
        checkOutput("rst.valids", 32'({drawValid, evenOddValid, regularValid}), 32'd0);
        checkOutput("rst.all", 32'({regularRouletteIn, evenOddRouletteIn, drawIn,
                                    busy, error, dispatchCount}), 32'd0);
        tick();

`ifdef DEMUX_TIMEOUT_EN
        // No ack: four valid cycles, then abort with error.
        applyStimulus(5'd3, 2'b00, 1'b1);
        load = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("to.valid4", 32'(regularValid), 32'd1);
        tick();
        checkOutput("to.drop", 32'(regularValid), 32'd0);
        checkOutput("to.error", 32'(error), 32'd1);
        checkOutput("to.count", 32'(dispatchCount), 32'd0);
        checkOutput("to.idle", 32'(busy), 32'd0);
        // Ack on the fourth cycle wins over the timeout.
        applyStimulus(5'd5, 2'b00, 1'b1);
        load = 1'b0;
        tick();
        tick();
        tick();
        regularAck = 1'b1;
        tick();
        regularAck = 1'b0;
        checkOutput("toAck.count", 32'(dispatchCount), 32'd1);
        checkOutput("toAck.error", 32'(error), 32'd0);
        checkOutput("toAck.done", 32'(busy), 32'd1);
        tick();
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_demux.md
INPUT_DEMUX -- requirements
Module: input_demux

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum DISPATCH cycles without ack before abort (used only with DEMUX_TIMEOUT_EN).
REQ-002 SHALL have port clock  in  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port gameInput  in  5  shared player value to dispatch.
REQ-005 SHALL have port select  in  2  target: 00 regular roulette, 01 even/odd roulette, 10 blackjack draw, 11 invalid.
REQ-006 SHALL have port load  in  1  capture request, sampled only in IDLE.
REQ-007 SHALL have ports regularRouletteIn / evenOddRouletteIn / drawIn  out  5 each  per-consumer data.
REQ-008 SHALL have ports regularValid / evenOddValid / drawValid  out  1 each  per-consumer valid.
REQ-009 SHALL have ports regularAck / evenOddAck / drawAck  in  1 each  per-consumer acknowledge.
REQ-010 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-011 SHALL have port error  out  1  sticky fault flag.
REQ-012 SHALL have port dispatchCount  out  8  completed dispatches, wraps 255->0.

Function
REQ-013 SHALL implement FSM states IDLE, DISPATCH, DONE.
REQ-014 IDLE with load=1 and select!=11 SHALL, at that edge, latch gameInput into the selected channel's data register and the select into a target register, then enter DISPATCH.
REQ-015 DISPATCH SHALL drive only the latched target's valid high; valid rises the cycle after load is sampled (latency 1).
REQ-016 Target ack=1 sampled in DISPATCH SHALL drop valid at that edge, increment dispatchCount, and enter DONE.
REQ-017 DONE SHALL last exactly one cycle, then return to IDLE; busy stays high in DONE.
REQ-018 Acks from non-target channels, and any ack outside DISPATCH, SHALL be ignored.
REQ-019 load while busy SHALL be ignored; gameInput/select changes after capture SHALL not affect the in-flight dispatch.
REQ-020 Each channel data output SHALL hold its last latched value until that channel is next loaded; non-target channels SHALL not change.
REQ-021 IDLE with load=1 and select=11 SHALL set error, stay in IDLE, and leave all data, valids and count unchanged.
REQ-022 error SHALL clear on the next accepted load with select!=11, and SHALL set if a set condition occurs at that same edge.
REQ-023 dispatchCount SHALL increment modulo 256, with no saturation.

Reset
REQ-024 reset=1 SHALL, at the next edge, force state IDLE, all data outputs 5'b00000, all valids 0, busy 0, error 0, dispatchCount 0, target register 00.
REQ-025 reset SHALL take priority over load and ack in the same cycle; reset mid-DISPATCH SHALL drop valid without incrementing the count.

Configuration
REQ-026 With macro DEMUX_TIMEOUT_EN defined, a cycle counter SHALL clear on DISPATCH entry; after TIMEOUT_CYCLES consecutive DISPATCH cycles without target ack, valid SHALL drop, error SHALL set, state SHALL return to IDLE, and the count SHALL not increment.
REQ-027 An ack arriving on the timeout cycle SHALL take priority, giving a normal completion.
REQ-028 Without DEMUX_TIMEOUT_EN, DISPATCH SHALL wait indefinitely; no counter logic is present, and error is set only by select=11.

Structure
REQ-029 A shared package game_pkg SHALL hold the select encodings (SEL_REGULAR=00, SEL_EVENODD=01, SEL_DRAW=10, SEL_INVALID=11), the FSM state encodings, and the 5-bit value width constant.
REQ-030 The timeout counter SHALL be a sub-module dispatch_timer, instantiated only under DEMUX_TIMEOUT_EN.

Verification
REQ-031 Reset, then load=1, select=00, gameInput=5'd17; ack regular 3 cycles later -> regularRouletteIn=17, regularValid high for exactly 3 cycles, busy high, dispatchCount=1, other channels 0.
REQ-032 load, select=10, gameInput=5'd9; drawAck held high already -> drawValid high exactly 1 cycle, DONE 1 cycle, IDLE on the 3rd edge after load.
REQ-033 load, select=11 -> error=1, no valid asserted; next load, select=01, value 4 -> error=0, evenOddRouletteIn=4.
REQ-034 During DISPATCH to the draw channel: pulse regularAck and load with a new value -> both ignored; drawIn unchanged; only drawAck completes the dispatch.
REQ-035 256 completed dispatches -> dispatchCount wraps to 0; reset asserted mid-DISPATCH -> all outputs at reset values the next cycle.
REQ-036 With DEMUX_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> valid drops after 4 cycles, error=1, count unchanged; ack on the 4th cycle -> normal completion.
